count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Run controller for the lab parameterised up-counter datapath: start/pause/stop/load
//  sequencing, programmable terminal count, one-shot or auto-reload operation.
//  Owns the count register and reports status, so top levels drive it from buttons or an FSM.
//  Sits between control logic (switch/button inputs) and the count display path.
// PARAMETERS
//  N      4  count width in bits
//  PRE_W  4  prescaler width; used only when COUNT_SEQ_PRESCALE_EN is defined
// PORTS
//  clk       in   1      system clock, rising edge
//  r         in   1      reset, asynchronous, active-low
//  start     in   1      start/resume request, sampled each clk
//  pause     in   1      pause request, honoured in RUN only
//  stop      in   1      abort to IDLE and clear count; highest priority
//  load      in   1      preset count from load_val; ignored in RUN
//  load_val  in   N      preset value
//  limit     in   N      terminal count
//  mode      in   1      0 = one-shot, 1 = auto-reload
//  prescale  in   PRE_W  tick divider (port exists only with COUNT_SEQ_PRESCALE_EN)
//  out       out  N      current count, registered
//  state     out  2      FSM state (IDLE=00, RUN=01, PAUSE=10, DONE=11)
//  busy      out  1      1 in RUN or PAUSE (decoded from the state register)
//  done      out  1      one-cycle pulse when a one-shot run terminates
//  wrap      out  1      one-cycle pulse on each auto-reload wrap
// BEHAVIOUR
//  - r=0 clears immediately: out=0, state=IDLE, busy=0, done=0, wrap=0, prescaler=0. All outputs are registered.
//  - Priority on every edge: stop > load > start > pause.
//  - stop in any state: next state is IDLE, out is 0, and the prescaler clears.
//  - load in IDLE/PAUSE/DONE: out <= load_val and the state is unchanged. In RUN, load is ignored.
//  - IDLE:  start -> RUN (out unchanged). pause is ignored.
//  - RUN:   one tick per clk. First tick is the edge after entry. Behaviour per tick:
//      out != limit           -> out <= out+1, mod 2^N. Passing 2^N-1 -> 0 is not a wrap event.
//      out == limit, mode=0   -> state DONE, done=1 for one cycle, out holds limit
//      out == limit, mode=1   -> out <= 0, wrap=1 for one cycle, stay in RUN
//    Consequences: limit=L from 0 gives period L+1 ticks. limit=0 with mode=1 holds 0 and pulses wrap every tick.
//  - RUN + pause -> PAUSE. That edge is not a tick; out and the prescaler freeze.
//  - PAUSE: start -> RUN, resuming from the frozen out and prescaler.
//  - DONE:  out holds. start -> RUN with out <= 0 (restart).
//  - out > limit (after a load): counts up through 2^N-1 -> 0 and on until it reaches limit.
//  - limit and mode changed mid-run take effect at the next tick compare.
//  - done and wrap are never high together, and each is high for exactly one clk.
// CONFIGURATION
//  - COUNT_SEQ_PRESCALE_EN defined: prescale port present.
//      The prescaler counts 0..prescale inside RUN; a tick occurs when it equals prescale.
//      So out advances every prescale+1 clks, and prescale=0 behaves like the macro-off build.
//      The prescaler clears on IDLE/DONE -> RUN, on stop and on reset, and holds in PAUSE.
//  - Macro undefined: no prescale port and no prescaler logic; every RUN clk is a tick.
// STRUCTURE
//  - count_seq_pkg holds:
//      typedef enum logic [1:0] state_t {IDLE, RUN, PAUSE, DONE}
//      localparams MODE_ONESHOT=1'b0 and MODE_RELOAD=1'b1
//  - Sub-module count_seq_prescaler (PRE_W; en, clr, div -> tick) is instantiated only under the macro.
//  - Top level holds the FSM, the count register and the done/wrap pulse registers.
// TESTING (N=4; macro off unless noted)
//  1. r=0 then 1; limit=3, mode=0; pulse start.
//     -> out 0,1,2,3 on successive clks; done=1 for one clk after out=3; state=DONE; out stays 3.
//  2. limit=2, mode=1; start.
//     -> out 0,1,2,0,1,2,...; wrap=1 exactly in the cycle out returns to 0; done never asserts.
//  3. limit=9, mode=0; start; pause at out=2; idle 3 clks; then start.
//     -> out holds 2 and state=PAUSE for 3 clks; resumes 3,4,...; busy=1 throughout.
//  4. In IDLE, load with load_val=13; limit=2; start.
//     -> out 13,14,15,0,1,2, then DONE with a done pulse; no wrap pulse at 15->0.
//  5. In PAUSE at out=5, assert stop and load together.
//     -> next state IDLE, out=0, busy=0.
//  6. r=0 asynchronously mid-count at out=6.
//     -> out=0, state=IDLE, done=wrap=0 immediately, before the next clk edge.
//     With COUNT_SEQ_PRESCALE_EN and prescale=2: out advances once every 3 clks.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer run controller.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/count_seq_prescaler.sv
// Tick divider for the count sequencer: one tick every div+1 enabled clocks.
// Only instantiated when COUNT_SEQ_PRESCALE_EN is defined.
module count_seq_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  assign tick = en && (cnt == div);

  // clr beats en so a restart or abort always begins a fresh division period
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == div) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run controller for the up-counter: start/pause/stop/load, terminal count, one-shot or reload.
// Define COUNT_SEQ_PRESCALE_EN to add the prescale port and tick divider.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int N = 4
`ifdef COUNT_SEQ_PRESCALE_EN
  , parameter int PRE_W = 4
`endif
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             load,
  input  logic [N-1:0]     load_val,
  input  logic [N-1:0]     limit,
  input  logic             mode,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PRE_W-1:0] prescale,
`endif
  output logic [N-1:0]     out,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t st;
  logic   tick;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic pre_en;
  logic pre_clr;

  // The divider only advances on RUN cycles that actually tick-compare, and
  // restarts whenever a fresh run begins from IDLE or DONE
  assign pre_en  = (st == RUN) && !stop && !pause;
  assign pre_clr = stop || (start && !load && ((st == IDLE) || (st == DONE)));

  count_seq_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .r    (r),
    .en   (pre_en),
    .clr  (pre_clr),
    .div  (prescale),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign state = st;
  assign busy  = (st == RUN) || (st == PAUSE);

  // Priority is stop > load > start > pause; load is a no-op while running
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      st   <= IDLE;
      out  <= '0;
      done <= 1'b0;
      wrap <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (stop) begin
        st  <= IDLE;
        out <= '0;
      end else if (load && (st != RUN)) begin
        out <= load_val;
      end else begin
        case (st)
          IDLE: begin
            if (start) st <= RUN;
          end
          RUN: begin
            if (pause) begin
              st <= PAUSE;
            end else if (tick) begin
              if (out != limit) begin
                out <= out + N'(1);
              end else begin
                case (mode)
                  MODE_ONESHOT: begin
                    st   <= DONE;
                    done <= 1'b1;
                  end
                  MODE_RELOAD: begin
                    out  <= '0;
                    wrap <= 1'b1;
                  end
                  default: ;
                endcase
              end
            end
          end
          PAUSE: begin
            if (start) st <= RUN;
          end
          DONE: begin
            if (start) begin
              st  <= RUN;
              out <= '0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios plus randomized run against a model.
// Honours COUNT_SEQ_PRESCALE_EN when the design is built with it.
module tb_count_sequencer;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic       clk;
  logic       r;
  logic       start;
  logic       pause;
  logic       stop;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] limit;
  logic       mode;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [3:0] prescale;
`endif
  logic [3:0] out;
  logic [1:0] state;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  // reference model: phase, count value, divider position, pulse flags
  int m_phase;
  int m_count;
  int m_pre;
  bit m_done;
  bit m_wrap;

  count_sequencer #(.N(4)) dut (
    .clk      (clk),
    .r        (r),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .mode     (mode),
`ifdef COUNT_SEQ_PRESCALE_EN
    .prescale (prescale),
`endif
    .out      (out),
    .state    (state),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic abort_to_idle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  // One clock edge of the behavioural rules, applied to the inputs currently driven
  task automatic model_edge();
    bit tick_now;
    int div;
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (stop) begin
      m_phase = S_IDLE;
      m_count = 0;
      m_pre   = 0;
      return;
    end
    if (load && m_phase != S_RUN) begin
      m_count = int'(load_val);
      return;
    end
    if (m_phase == S_IDLE && start) begin
      m_phase = S_RUN;
      m_pre   = 0;
    end else if (m_phase == S_DONE && start) begin
      m_phase = S_RUN;
      m_count = 0;
      m_pre   = 0;
    end else if (m_phase == S_PAUSE && start) begin
      m_phase = S_RUN;
    end else if (m_phase == S_RUN && pause) begin
      m_phase = S_PAUSE;
    end else if (m_phase == S_RUN) begin
`ifdef COUNT_SEQ_PRESCALE_EN
      div = int'(prescale);
`else
      div = 0;
`endif
      tick_now = (m_pre == div);
      m_pre = tick_now ? 0 : (m_pre + 1) % 16;
      if (tick_now) begin
        if (m_count != int'(limit)) begin
          m_count = (m_count + 1) % 16;
        end else if (mode) begin
          m_count = 0;
          m_wrap  = 1'b1;
        end else begin
          m_phase = S_DONE;
          m_done  = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    r = 1'b0;
    #12;
    checks++;
    if (out !== 4'd0 || state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: out=%0d state=%0d busy=%0b done=%0b wrap=%0b, expected all 0",
               out, state, busy, done, wrap);
    end
    @(negedge clk);
    r = 1'b1;
    cycle();
    checks++;
    if (out !== 4'd0 || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_release: out=%0d state=%0d, expected 0/0", out, state);
    end
  endtask

  task automatic test_oneshot();
    limit = 4'd3;
    mode  = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out !== 4'(k) || state !== 2'd1 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL oneshot_count[%0d]: out=%0d state=%0d done=%0b, expected out=%0d state=1 done=0",
                 k, out, state, done, k);
      end
      cycle();
    end
    checks++;
    if (state !== 2'd3 || done !== 1'b1 || out !== 4'd3 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oneshot_done: state=%0d done=%0b out=%0d busy=%0b, expected 3/1/3/0",
               state, done, out, busy);
    end
    cycle();
    checks++;
    if (state !== 2'd3 || done !== 1'b0 || out !== 4'd3) begin
      errors++;
      $display("[TB] FAIL oneshot_hold: state=%0d done=%0b out=%0d, expected 3/0/3", state, done, out);
    end
  endtask

  task automatic test_reload();
    int exp;
    abort_to_idle();
    limit = 4'd2;
    mode  = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      exp = i % 3;
      checks++;
      if (out !== 4'(exp) || wrap !== (exp == 0) || done !== 1'b0 || state !== 2'd1) begin
        errors++;
        $display("[TB] FAIL reload[%0d]: out=%0d wrap=%0b done=%0b state=%0d, expected out=%0d wrap=%0b done=0 state=1",
                 i, out, wrap, done, state, exp, exp == 0);
      end
    end
  endtask

  task automatic test_pause_resume();
    abort_to_idle();
    limit = 4'd9;
    mode  = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    pause = 1'b1;
    cycle();
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out !== 4'd2 || state !== 2'd2 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL pause_hold[%0d]: out=%0d state=%0d busy=%0b, expected 2/2/1", i, out, state, busy);
      end
      cycle();
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out !== 4'(2 + i) || state !== 2'd1 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL resume[%0d]: out=%0d state=%0d busy=%0b, expected %0d/1/1",
                 i, out, state, busy, 2 + i);
      end
      cycle();
    end
  endtask

  task automatic test_load_wrap();
    int exp;
    abort_to_idle();
    load     = 1'b1;
    load_val = 4'd13;
    cycle();
    load = 1'b0;
    checks++;
    if (out !== 4'd13 || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL load_idle: out=%0d state=%0d, expected 13/0", out, state);
    end
    limit = 4'd2;
    mode  = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      exp = (13 + i) % 16;
      checks++;
      if (out !== 4'(exp) || wrap !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL load_count[%0d]: out=%0d wrap=%0b done=%0b, expected %0d/0/0",
                 i, out, wrap, done, exp);
      end
    end
    cycle();
    checks++;
    if (state !== 2'd3 || done !== 1'b1 || out !== 4'd2) begin
      errors++;
      $display("[TB] FAIL load_done: state=%0d done=%0b out=%0d, expected 3/1/2", state, done, out);
    end
  endtask

  task automatic test_stop_over_load();
    abort_to_idle();
    limit = 4'd9;
    mode  = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    pause = 1'b1;
    cycle();
    pause = 1'b0;
    checks++;
    if (out !== 4'd5 || state !== 2'd2) begin
      errors++;
      $display("[TB] FAIL stop_setup: out=%0d state=%0d, expected 5/2", out, state);
    end
    stop     = 1'b1;
    load     = 1'b1;
    load_val = 4'd7;
    cycle();
    stop = 1'b0;
    load = 1'b0;
    checks++;
    if (out !== 4'd0 || state !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_load: out=%0d state=%0d busy=%0b, expected 0/0/0", out, state, busy);
    end
  endtask

  task automatic test_async_reset();
    abort_to_idle();
    limit = 4'd9;
    mode  = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (6) cycle();
    checks++;
    if (out !== 4'd6) begin
      errors++;
      $display("[TB] FAIL async_setup: out=%0d, expected 6", out);
    end
    #2 r = 1'b0;
    #1;
    checks++;
    if (out !== 4'd0 || state !== 2'd0 || done !== 1'b0 || wrap !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: out=%0d state=%0d done=%0b wrap=%0b busy=%0b, expected all 0",
               out, state, done, wrap, busy);
    end
    #2 r = 1'b1;
    cycle();
  endtask

`ifdef COUNT_SEQ_PRESCALE_EN
  task automatic test_prescale();
    abort_to_idle();
    prescale = 4'd2;
    limit    = 4'd15;
    mode     = 1'b1;
    start    = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      checks++;
      if (out !== 4'(i / 3)) begin
        errors++;
        $display("[TB] FAIL prescale[%0d]: out=%0d, expected %0d", i, out, i / 3);
      end
    end
    prescale = 4'd0;
  endtask
`endif

  task automatic test_random();
    abort_to_idle();
    m_phase = S_IDLE;
    m_count = 0;
    m_pre   = 0;
    m_done  = 1'b0;
    m_wrap  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) begin
        limit = 4'($urandom_range(0, 15));
        mode  = 1'($urandom_range(0, 1));
`ifdef COUNT_SEQ_PRESCALE_EN
        prescale = 4'($urandom_range(0, 3));
`endif
      end
      start    = ($urandom_range(0, 3) == 0);
      pause    = ($urandom_range(0, 5) == 0);
      stop     = ($urandom_range(0, 24) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      model_edge();
      cycle();
      checks++;
      if (out !== 4'(m_count) || state !== 2'(m_phase) || done !== m_done || wrap !== m_wrap ||
          busy !== (m_phase == S_RUN || m_phase == S_PAUSE)) begin
        errors++;
        $display("[TB] FAIL random[%0d]: out=%0d state=%0d done=%0b wrap=%0b busy=%0b, expected out=%0d state=%0d done=%0b wrap=%0b",
                 i, out, state, done, wrap, busy, m_count, m_phase, m_done, m_wrap);
      end
      checks++;
      if (done === 1'b1 && wrap === 1'b1) begin
        errors++;
        $display("[TB] FAIL random_exclusive[%0d]: done=%0b wrap=%0b, expected not both high", i, done, wrap);
      end
    end
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
  endtask

  initial begin
    r        = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    stop     = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    limit    = 4'd0;
    mode     = 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
    prescale = 4'd0;
`endif
    test_reset();
    test_oneshot();
    test_reload();
    test_pause_resume();
    test_load_wrap();
    test_stop_over_load();
    test_async_reset();
`ifdef COUNT_SEQ_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
